// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWE,
  input  logic             LoWE,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_dbz;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mstep;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_dstep;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed = ~Op[0];
  assign w_dbz    = Op[1] && (SrcB == '0);
  assign w_abs_a  = (w_signed && SrcA[WIDTH-1]) ? (-SrcA) : SrcA;
  assign w_abs_b  = (w_signed && SrcB[WIDTH-1]) ? (-SrcB) : SrcB;

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB-first.
  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mstep = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_dstep = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                  : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_lo ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg_lo ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (Start) begin
            r_count  <= '0;
            r_b      <= w_abs_b;
            r_is_div <= Op[1];
            // Divide-by-zero presets HI=SrcA, LO=all-ones with no sign fix-up.
            r_neg_lo <= ~w_dbz & w_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_neg_hi <= ~w_dbz & w_signed & Op[1] & SrcA[WIDTH-1];
            if (w_dbz) begin
              r_acc   <= {SrcA, {WIDTH{1'b1}}};
              r_state <= StFix;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_state <= StCalc;
            end
          end else begin
            if (HiWE) r_hi <= WriteData;
            if (LoWE) r_lo <= WriteData;
          end
        end
        StCalc: begin
          r_acc   <= r_is_div ? w_dstep : w_mstep;
          r_count <= r_count + CW'(1);
          if (r_count == LastCount) r_state <= StFix;
        end
        StFix: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Busy = (r_state != StIdle);
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WriteData;
  logic        HiWE, LoWE;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWE(HiWE), .LoWE(LoWE), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from plain arithmetic on the architectural operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Called at a negedge with the DUT idle; leaves at the negedge where Done is seen.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit disturb);
    int  n;
    int  exp_lat;
    bit  busy_ok, hold_ok, seen;
    exp_lat = (op[1] && b == 32'd0) ? 1 : 33;
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; HiWE = 1'b0; LoWE = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
    n = 1; busy_ok = 1'b1; hold_ok = 1'b1; seen = 1'b0;
    while (!seen && n <= 100) begin
      if (Done) seen = 1'b1;
      else begin
        if (!Busy) busy_ok = 1'b0;
        if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
        if (disturb && n == 5) begin
          Start = 1'b1; Op = 2'b11; HiWE = 1'b1; WriteData = 32'hDEADBEEF;
        end else begin
          Start = 1'b0; HiWE = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    Start = 1'b0; HiWE = 1'b0;
    check({name, "_latency"}, 64'(n - 1), 64'(exp_lat));
    check({name, "_busy"}, {63'b0, busy_ok}, 64'd1);
    check({name, "_hold"}, {63'b0, hold_ok}, 64'd1);
    check({name, "_busy_at_done"}, {63'b0, Busy}, 64'd0);
    check({name, "_hi"}, {32'b0, HI}, {32'b0, ehi});
    check({name, "_lo"}, {32'b0, LO}, {32'b0, elo});
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
    vecs[7] = '{2'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};

    rst = 1'b1; Start = 1'b0; Op = 2'd0; SrcA = '0; SrcB = '0;
    HiWE = 1'b0; LoWE = 1'b0; WriteData = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", {32'b0, HI}, 64'd0);
    check("reset_lo", {32'b0, LO}, 64'd0);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check("reset_done", {63'b0, Done}, 64'd0);

    // Back-to-back: each op starts in the cycle the previous Done is high.
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, 1'b0);

    @(negedge clk);
    check("done_pulse_width", {63'b0, Done}, 64'd0);

    run_op("disturb_multu", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);

    LoWE = 1'b1; WriteData = 32'h12345678;
    @(negedge clk);
    LoWE = 1'b0;
    check("mtlo_lo", {32'b0, LO}, 64'h12345678);
    check("mtlo_hi", {32'b0, HI}, 64'd0);

    HiWE = 1'b1; LoWE = 1'b1; WriteData = 32'hA5A5A5A5;
    @(negedge clk);
    HiWE = 1'b0; LoWE = 1'b0;
    check("mthi_mtlo_hi", {32'b0, HI}, 64'hA5A5A5A5);
    check("mthi_mtlo_lo", {32'b0, LO}, 64'hA5A5A5A5);
    m_hi = 32'hA5A5A5A5; m_lo = 32'hA5A5A5A5;

    // Start wins over a simultaneous MTHI/MTLO.
    HiWE = 1'b1; LoWE = 1'b1; WriteData = 32'h00000055;
    run_op("start_wins", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    Start = 1'b1; Op = 2'd0; SrcA = 32'hFFFFFFF9; SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_hi", {32'b0, HI}, 64'd0);
    check("midreset_lo", {32'b0, LO}, 64'd0);
    check("midreset_busy", {63'b0, Busy}, 64'd0);
    check("midreset_done", {63'b0, Done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    run_op("after_reset", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      r = model(op, a, b);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, r[63:32], r[31:0], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file and consumes ReadData1/ReadData2 as its SrcA/SrcB operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles, and raises Busy so control can stall the pipeline. HI and LO feed the MFHI/MFLO write-back mux, and MTHI/MTLO write them directly.

## Interface
- WIDTH, 32, operand width; HI/LO width; the product is 2*WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Start  in  1  launch an operation; sampled only in IDLE.
- Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  in  WIDTH  multiplicand or dividend (register file ReadData1).
- SrcB  in  WIDTH  multiplier or divisor (register file ReadData2).
- HiWE  in  1  MTHI write enable.
- LoWE  in  1  MTLO write enable.
- WriteData  in  WIDTH  MTHI/MTLO data (register file ReadData1).
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  out  WIDTH  high product word, or remainder.
- LO  out  WIDTH  low product word, or quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, Start=1:
  - latch |SrcA| and |SrcB| (absolute values for signed ops; raw values for unsigned ops);
  - latch the result-sign flags;
  - clear the iteration count;
  - go to CALC.
- IDLE, Start=1, DIV/DIVU with SrcB==0: skip CALC and go to FIX with a preset result of HI=SrcA, LO=all-ones.
- CALC:
  - runs one radix-2 step per cycle for 32 cycles (count 0..31);
  - multiply uses shift-add into a 64-bit accumulator;
  - divide uses restoring shift-subtract: a 32-bit partial remainder plus a quotient shift register;
  - leaves to FIX after the count==31 step.
- FIX:
  - applies sign correction;
  - signed multiply: the 64-bit product is negated if the operand signs differ;
  - signed divide: the quotient is negated if the signs differ, and the remainder takes the sign of the dividend (truncation toward zero);
  - writes HI/LO, pulses Done and returns to IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the unsigned path; no trap.
- MTHI/MTLO:
  - HiWE/LoWE are accepted only in IDLE with Start=0; HI/LO are written at the next edge;
  - both may be set together;
  - ignored while Busy=1 or when Start=1 in the same cycle (Start wins).
- Start while Busy=1 is ignored; the in-flight operation and operands are unaffected.
- HI/LO hold their previous values throughout CALC; they change only in FIX or via MTHI/MTLO.

## Timing
- Reset (asynchronous, immediate): state=IDLE, HI=0, LO=0, Busy=0, Done=0, count=0. Reset mid-operation abandons it with no HI/LO update.
- Edge E0 samples Start. Busy is high from after E0 until E33; it is combinationally derived from state != IDLE.
- Normal operation:
  - CALC occupies E1..E32, and FIX is active in the cycle after E32;
  - E33 writes HI/LO and returns to IDLE;
  - Done=1 for exactly the cycle after E33, i.e. a 33-cycle latency from the Start edge to the result.
- Divide-by-zero: FIX follows E0; E1 writes HI/LO; Done=1 in the cycle after E1.
- A new Start is accepted in the same cycle Done=1, since the state is already IDLE.
- Operands are captured at E0; changes on SrcA/SrcB/Op afterwards have no effect.

## Test plan
- Reset then MULTU SrcA=SrcB=0xFFFFFFFF, Start at E0 -> Busy high E0..E33, Done pulse after E33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT SrcA=0xFFFFFFF9 (-7), SrcB=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT -1*-1 -> HI=0, LO=1.
- DIV SrcA=0xFFFFFFF9, SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU SrcA=100, SrcB=0 -> Done after E1, HI=100, LO=0xFFFFFFFF.
- During MULTU 5*6:
  - assert Start with Op=DIVU, and HiWE=1 with WriteData=0xDEADBEEF -> both ignored, final HI=0, LO=30;
  - MTLO 0x12345678 afterwards in IDLE -> LO=0x12345678 at the next edge, HI unchanged.
- Assert rst at count 10 of a MULT -> HI=LO=0, Busy=Done=0 immediately; a subsequent MULTU 3*4 returns LO=12 with the normal 33-cycle latency.
